// File: rtl/sub_32bit.sv
// rtl/sub_32bit.sv - unsigned 32-bit subtractor with borrow, plus registered result and sticky borrow
//
// Purpose: Diff = (A - B) mod 2^32 and B_out = (A < B), built from four chained
// 8-bit borrow slices. The same result is also registered on clk, together
// with a sticky flag that remembers any registered borrow until reset.
//
// Ports:
//   clk           in   1   rising edge updates the registered outputs only
//   rst           in   1   asynchronous, active-high; clears registered outputs
//   A             in   32  minuend, unsigned
//   B             in   32  subtrahend, unsigned
//   Diff          out  32  combinational (A - B) mod 2^32
//   B_out         out  1   combinational borrow-out, 1 iff A < B
//   Diff_q        out  32  Diff registered on clk
//   B_out_q       out  1   B_out registered on clk
//   borrow_sticky out  1   set by a registered borrow, held until reset

module sub_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Diff,
  output logic        B_out,
  output logic [31:0] Diff_q,
  output logic        B_out_q,
  output logic        borrow_sticky
);

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  // One borrow slice: returns {borrow_out, difference}. The borrow ripples
  // bit by bit inside the slice, and slice to slice through bin.
  function automatic logic [SLICE:0] slice_sub(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             bin
  );
    logic [SLICE-1:0] d;
    logic             br;
    d  = '0;
    br = bin;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    return {br, d};
  endfunction

  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;

  always_comb begin
    logic [SLICE:0] r;
    diff_c   = '0;
    borrow_c = 1'b0;   // slice 0 borrow-in
    r        = '0;
    for (int k = 0; k < NSLICE; k++) begin
      r = slice_sub(A[k*SLICE +: SLICE], B[k*SLICE +: SLICE], borrow_c);
      diff_c[k*SLICE +: SLICE] = r[SLICE-1:0];
      borrow_c = r[SLICE];
    end
  end

  assign Diff  = diff_c;
  assign B_out = borrow_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Diff_q        <= '0;
      B_out_q       <= 1'b0;
      borrow_sticky <= 1'b0;
    end else begin
      Diff_q        <= diff_c;
      B_out_q       <= borrow_c;
      // Uses the borrow being captured this edge, not the previous B_out_q.
      borrow_sticky <= borrow_sticky | borrow_c;
    end
  end

endmodule

// File: tb/tb_sub_32bit.sv
// tb/tb_sub_32bit.sv - self-checking bench for sub_32bit

module tb_sub_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Diff;
  logic        B_out;
  logic [31:0] Diff_q;
  logic        B_out_q;
  logic        borrow_sticky;

  int checks;
  int errors;

  logic [31:0] exp_dq;
  logic        exp_bq;
  logic        exp_st;

  sub_32bit dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .Diff          (Diff),
    .B_out         (B_out),
    .Diff_q        (Diff_q),
    .B_out_q       (B_out_q),
    .borrow_sticky (borrow_sticky)
  );

  // Reference: plain modular arithmetic and an unsigned compare.
  function automatic logic [31:0] ref_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

  function automatic logic ref_borrow(input logic [31:0] a, input logic [31:0] b);
    return (a < b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".diff"}, Diff, ref_diff(A, B));
    check({tag, ".bout"}, {31'd0, B_out}, {31'd0, ref_borrow(A, B)});
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".diff_q"}, Diff_q, exp_dq);
    check({tag, ".bout_q"}, {31'd0, B_out_q}, {31'd0, exp_bq});
    check({tag, ".sticky"}, {31'd0, borrow_sticky}, {31'd0, exp_st});
  endtask

  // One clock pulse; the model captures the operands present at the edge.
  // Outputs are then sampled mid-low-phase, away from any edge.
  task automatic tick();
    #1;
    exp_dq = ref_diff(A, B);
    exp_bq = ref_borrow(A, B);
    exp_st = exp_st | exp_bq;
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #3;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    A      = 32'd0;
    B      = 32'd0;
    exp_dq = 32'd0;
    exp_bq = 1'b0;
    exp_st = 1'b0;

    // Reset state, and combinational path with clock idle and reset held
    #2;
    check_regs("reset");
    A = 32'd5; B = 32'd3;
    #10;
    check("5m3.diff", Diff, 32'd2);
    check("5m3.bout", {31'd0, B_out}, 32'd0);
    check_regs("reset_hold");

    // Release reset; 3 - 5 wraps and sets the sticky flag
    rst = 1'b0;
    A = 32'd3; B = 32'd5;
    #10;
    check("3m5.diff", Diff, 32'hFFFF_FFFE);
    check("3m5.bout", {31'd0, B_out}, 32'd1);
    tick();
    check("3m5.diff_q", Diff_q, 32'hFFFF_FFFE);
    check("3m5.bout_q", {31'd0, B_out_q}, 32'd1);
    check("3m5.sticky", {31'd0, borrow_sticky}, 32'd1);

    // Borrow across slice boundaries
    A = 32'h0000_0100; B = 32'h0000_0001;
    #10;
    check("slice.diff", Diff, 32'h0000_00FF);
    check("slice.bout", {31'd0, B_out}, 32'd0);
    A = 32'h8000_0000; B = 32'h0000_0001;
    #10;
    check("msb.diff", Diff, 32'h7FFF_FFFF);
    check("msb.bout", {31'd0, B_out}, 32'd0);

    // Boundary operands
    A = 32'd0; B = 32'd1;
    #10;
    check("0m1.diff", Diff, 32'hFFFF_FFFF);
    check("0m1.bout", {31'd0, B_out}, 32'd1);
    A = 32'hFFFF_FFFF; B = 32'd0;
    #10;
    check("ffm0.diff", Diff, 32'hFFFF_FFFF);
    check("ffm0.bout", {31'd0, B_out}, 32'd0);
    A = 32'h1234_5678; B = 32'h1234_5678;
    #10;
    check("eq.diff", Diff, 32'd0);
    check("eq.bout", {31'd0, B_out}, 32'd0);

    // Random pairs, combinational and registered, with occasional equal/zero operands
    for (int i = 0; i < 100; i++) begin
      A = $urandom;
      case ($urandom_range(0, 7))
        0: B = A;
        1: B = 32'd0;
        2: B = A + 32'd1;
        default: B = $urandom;
      endcase
      #10;
      check_comb("rand");
      tick();
      check_regs("rand");
    end

    // Reset between clock edges clears registers at once; comb path keeps tracking
    A = 32'd1; B = 32'd2;
    tick();
    check_regs("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    exp_dq = 32'd0;
    exp_bq = 1'b0;
    exp_st = 1'b0;
    check_regs("mid_rst");
    A = 32'd10; B = 32'd20;
    #5;
    check_comb("rst_comb");
    check_regs("rst_comb");
    rst = 1'b0;
    #5;

    // First edge after reset captures current inputs
    tick();
    check_regs("post_rst");

    // Equal all-ones: no borrow, sticky not set
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_dq = 32'd0;
    exp_bq = 1'b0;
    exp_st = 1'b0;
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    #10;
    check("ffeq.diff", Diff, 32'd0);
    check("ffeq.bout", {31'd0, B_out}, 32'd0);
    tick();
    check_regs("ffeq");
    check("ffeq.sticky0", {31'd0, borrow_sticky}, 32'd0);
    A = 32'd0; B = 32'd0;
    tick();
    check("zz.sticky0", {31'd0, borrow_sticky}, 32'd0);

    // Sticky set, then a no-borrow cycle leaves it held
    A = 32'd0; B = 32'd1;
    tick();
    check("set.sticky", {31'd0, borrow_sticky}, 32'd1);
    A = 32'd0; B = 32'd0;
    tick();
    check_regs("hold");
    check("hold.sticky", {31'd0, borrow_sticky}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
